// File: rtl/parking_slot_allocator.sv
// parking_slot_allocator: tracks 4 slots, grants the lowest free slot, frees on exit, times the gate
module parking_slot_allocator #(
  parameter int GATE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [1:0] exit_slot,
  output logic [1:0] L,
  output logic [3:0] occupied,
  output logic [2:0] count,
  output logic       full,
  output logic       entry_grant,
  output logic       entry_denied,
  output logic       exit_ack,
  output logic       exit_err,
  output logic       gate_open
);
  typedef enum logic {IDLE, GATE} state_t;
  localparam logic [7:0] GC = 8'(GATE_CYCLES);
  state_t state, state_nx;
  logic [7:0] timer;
  logic idle, exit_ok, serve_entry, serve_exit;
  logic [1:0] free_slot;
  // request arbitration: entry beats exit unless the lot is full
  always_comb begin
    idle = state == IDLE;
    exit_ok = exit_req && occupied[exit_slot];
    serve_entry = idle && entry_req && !full;
    serve_exit = idle && !serve_entry && exit_ok;
    free_slot = !occupied[0] ? 2'd0 : !occupied[1] ? 2'd1 : !occupied[2] ? 2'd2 : 2'd3;
  end
  // next state: a served request opens the gate, timer expiry closes it
  always_comb begin
    state_nx = (serve_entry || serve_exit) ? GATE : (state == GATE && timer == 8'd1) ? IDLE : state;
  end
  // state, gate timer, occupancy bookkeeping and one-cycle pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      L <= '0;
      occupied <= '0;
      count <= '0;
      full <= 1'b0;
      entry_grant <= 1'b0;
      entry_denied <= 1'b0;
      exit_ack <= 1'b0;
      exit_err <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= (serve_entry || serve_exit) ? GC : timer - {7'd0, timer != 8'd0};
      entry_grant <= serve_entry;
      exit_ack <= serve_exit;
      exit_err <= idle && exit_req && !occupied[exit_slot] && !serve_entry;
      entry_denied <= idle && entry_req && full && !exit_ok;
      if (serve_entry) begin
        L <= free_slot;
        occupied[free_slot] <= 1'b1;
        count <= count + 3'd1;
        full <= count == 3'd3;
      end else if (serve_exit) begin
        occupied[exit_slot] <= 1'b0;
        count <= count - 3'd1;
        full <= 1'b0;
      end
    end
  end
  // gate is open for every cycle spent in GATE
  always_comb begin
    gate_open = state == GATE;
  end
endmodule

// File: doc/parking_slot_allocator.md
Name: parking_slot_allocator

Overview:
- Sequential controller directly upstream of the slot-select mux stage. Tracks occupancy of the 4 parking slots, assigns the lowest free slot to an arriving car, and frees a slot on exit.
- Drives the 2-bit location L consumed by the 2-bit slot mux, plus gate control and status flags.
- One request is served per gate cycle; the gate is held open for a fixed interval after each served request.

Parameters:
- GATE_CYCLES, 4, number of clock cycles gate_open stays high after a served entry or exit; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- entry_req  input  1  car present at entry sensor (level; sampled in IDLE only)
- exit_req  input  1  car leaving (level; sampled in IDLE only)
- exit_slot  input  2  slot index being vacated, valid with exit_req
- L  output  2  most recently assigned slot index (feeds slot mux)
- occupied  output  4  bit i = slot i occupied
- count  output  3  number of occupied slots, 0..4
- full  output  1  count == 4
- entry_grant  output  1  one-cycle pulse: slot assigned, L valid
- entry_denied  output  1  one-cycle pulse: entry refused, lot full
- exit_ack  output  1  one-cycle pulse: slot freed
- exit_err  output  1  one-cycle pulse: exit_req for an unoccupied slot
- gate_open  output  1  gate actuator enable

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; L=0, occupied=0, count=0, full=0, all pulses=0, gate_open=0, gate timer=0. Reset wins over any request in the same cycle and aborts a gate interval mid-operation.
- States: IDLE and GATE.
- IDLE, evaluated in priority order at each edge:
  - a) entry_req=1 and full=0:
    - Slot s = lowest index with occupied[s]=0.
    - Next cycle: L=s, occupied[s]=1, count+1, entry_grant=1 for one cycle.
    - Move to GATE.
  - b) entry_req=1, full=1, exit_req=1 and occupied[exit_slot]=1:
    - Exit is served (see c). entry_denied stays 0; the car retries after the gate interval.
  - c) exit_req=1 and occupied[exit_slot]=1:
    - Next cycle: occupied[exit_slot]=0, count-1, exit_ack=1 for one cycle.
    - Move to GATE. L is unchanged.
  - d) exit_req=1 and occupied[exit_slot]=0:
    - exit_err=1 for one cycle. No state change; stay IDLE.
    - If entry_req=1 and full=1 in the same cycle, entry_denied also pulses.
  - e) entry_req=1, full=1, and no exit served: entry_denied=1 for one cycle; stay IDLE.
  - Simultaneous entry and exit with lot not full: entry is served first; the exit is served on a later IDLE cycle if still asserted.
- GATE:
  - gate_open=1 from the cycle after entry into GATE for exactly GATE_CYCLES cycles. Internal down-counter loads GATE_CYCLES on entry to GATE.
  - Then return to IDLE, with gate_open=0 in the first IDLE cycle.
  - entry_req and exit_req are ignored in GATE; they are not queued.
  - A still-asserted request is re-evaluated in the first IDLE cycle. A minimum of one IDLE cycle separates consecutive gate intervals.
- Latency: request sampled in IDLE → grant/ack/occupancy update visible 1 cycle later → gate_open rises in that same cycle.
- full and count are registered and consistent with occupied every cycle: count = popcount(occupied).
- count never wraps: entry is blocked at 4, and exit of an empty slot is rejected, so count stays within 0..4.
- L holds its value across exits and denials; it changes only on entry_grant.
- All pulse outputs are exactly one cycle wide and are never asserted in GATE except in the first cycle after the transition.

Test Plan:
- Reset, then entry_req held through 4 gate intervals → L sequence 0,1,2,3; occupied 0001,0011,0111,1111; count=4, full=1; each grant followed by gate_open high for 4 cycles.
- Full lot, entry_req only → entry_denied single pulse, occupied stays 1111, gate_open=0.
- occupied=1111, exit_req with exit_slot=2 → exit_ack; occupied=1011, count=3, L unchanged (3). Next entry → L=2, occupied=1111.
- occupied=0101, exit_req with exit_slot=1 → exit_err pulse, no gate, occupied=0101. Simultaneous entry_req and exit_req(slot 0) with lot not full → entry served first (L=1, occupied=0111); exit served after the gate interval (occupied=0110).
- occupied=1111, entry_req and exit_req(slot 0) together → exit_ack, entry_denied=0, occupied=1110. Entry then granted in the next IDLE cycle with L=0.
- Assert rst during the 2nd gate cycle → next cycle gate_open=0, occupied=0, count=0, L=0, state IDLE. Also check that a request arriving mid-GATE is ignored until IDLE.
